// File: rtl/prn_gen_ctrl.sv
// Sequencing controller for one tracking channel's BOC PRN generator.
// Handles load/run/slew sequencing, epoch-aligned FCW updates and integration dump strobes.
module prn_gen_ctrl #(
    parameter int ACC_WIDTH  = 32,
    parameter int EPW        = 6,
    parameter int SLEW_WIDTH = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  rx_start,
    input  logic                  rx_stop,
    input  logic                  rx_cfg_valid,
    output logic                  tx_cfg_ready,
    input  logic [ACC_WIDTH-1:0]  rx_cfg_fcw,
    input  logic [1:0]            rx_cfg_paral,
    input  logic [EPW-1:0]        rx_cfg_int,
    input  logic                  rx_slew_valid,
    output logic                  tx_slew_ready,
    input  logic [SLEW_WIDTH-1:0] rx_slew_cycles,
    input  logic                  rx_prn_eop,
    output logic                  tx_gen_rst,
    output logic [ACC_WIDTH-1:0]  tx_gen_fcw,
    output logic [1:0]            tx_gen_paral,
    output logic                  tx_dump,
    output logic [EPW-1:0]        tx_epoch_cnt,
    output logic                  tx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_SLEW = 2'd3
    } state_t;

    localparam logic [EPW-1:0]        EPOCH_ONE = EPW'(1);
    localparam logic [SLEW_WIDTH-1:0] SLEW_ONE  = SLEW_WIDTH'(1);

    // Last epoch index of an integration; a programmed length of 0 behaves as 1.
    function automatic logic [EPW-1:0] last_epoch(input logic [EPW-1:0] n);
        return (n == '0) ? '0 : (n - EPOCH_ONE);
    endfunction

    state_t                  state_r, state_nx_s;
    logic [ACC_WIDTH-1:0]    fcw_a_r, fcw_a_nx_s, fcw_p_r, fcw_p_nx_s;
    logic [1:0]              paral_a_r, paral_a_nx_s, paral_p_r, paral_p_nx_s;
    logic [EPW-1:0]          int_a_r, int_a_nx_s, int_p_r, int_p_nx_s;
    logic                    cfg_pend_r, cfg_pend_nx_s;
    logic [SLEW_WIDTH-1:0]   slew_cnt_r, slew_cnt_nx_s;
    logic                    slew_pend_r, slew_pend_nx_s;
    logic [EPW-1:0]          epoch_nx_s;
    logic                    dump_nx_s;
    logic                    cfg_acc_s, slew_acc_s;

    assign cfg_acc_s  = rx_cfg_valid & tx_cfg_ready;
    assign slew_acc_s = rx_slew_valid & tx_slew_ready;

    // Next-state, register-update and strobe decisions.
    always_comb begin
        state_nx_s     = state_r;
        fcw_a_nx_s     = fcw_a_r;
        paral_a_nx_s   = paral_a_r;
        int_a_nx_s     = int_a_r;
        fcw_p_nx_s     = fcw_p_r;
        paral_p_nx_s   = paral_p_r;
        int_p_nx_s     = int_p_r;
        cfg_pend_nx_s  = cfg_pend_r;
        slew_cnt_nx_s  = slew_cnt_r;
        slew_pend_nx_s = slew_pend_r;
        epoch_nx_s     = tx_epoch_cnt;
        dump_nx_s      = 1'b0;
        if (rx_stop) begin
            // Stop overrides everything, including a simultaneous start.
            state_nx_s     = ST_IDLE;
            cfg_pend_nx_s  = 1'b0;
            slew_pend_nx_s = 1'b0;
            slew_cnt_nx_s  = '0;
            epoch_nx_s     = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    epoch_nx_s = '0;
                    if (cfg_acc_s) begin
                        fcw_a_nx_s   = rx_cfg_fcw;
                        paral_a_nx_s = rx_cfg_paral;
                        int_a_nx_s   = rx_cfg_int;
                    end else begin
                        fcw_a_nx_s   = fcw_a_r;
                    end
                    if (rx_start) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_nx_s = ST_RUN;
                    if (cfg_acc_s) begin
                        fcw_p_nx_s    = rx_cfg_fcw;
                        paral_p_nx_s  = rx_cfg_paral;
                        int_p_nx_s    = rx_cfg_int;
                        cfg_pend_nx_s = 1'b1;
                    end else begin
                        cfg_pend_nx_s = cfg_pend_r;
                    end
                end
                ST_RUN: begin
                    if (rx_prn_eop) begin
                        // Dump decision uses the integration length in force before any swap.
                        if (tx_epoch_cnt >= last_epoch(int_a_r)) begin
                            epoch_nx_s = '0;
                            dump_nx_s  = 1'b1;
                        end else begin
                            epoch_nx_s = tx_epoch_cnt + EPOCH_ONE;
                        end
                        if (cfg_pend_r) begin
                            fcw_a_nx_s    = fcw_p_r;
                            paral_a_nx_s  = paral_p_r;
                            int_a_nx_s    = int_p_r;
                            cfg_pend_nx_s = 1'b0;
                        end else begin
                            cfg_pend_nx_s = cfg_pend_r;
                        end
                        if (slew_pend_r) begin
                            state_nx_s     = ST_SLEW;
                            slew_pend_nx_s = 1'b0;
                        end else begin
                            state_nx_s     = ST_RUN;
                        end
                    end else begin
                        epoch_nx_s = tx_epoch_cnt;
                    end
                    if (cfg_acc_s) begin
                        fcw_p_nx_s    = rx_cfg_fcw;
                        paral_p_nx_s  = rx_cfg_paral;
                        int_p_nx_s    = rx_cfg_int;
                        cfg_pend_nx_s = 1'b1;
                    end else begin
                        fcw_p_nx_s    = fcw_p_nx_s;
                    end
                    // A zero-length slew completes the handshake but is dropped.
                    if (slew_acc_s && (rx_slew_cycles != '0)) begin
                        slew_cnt_nx_s  = rx_slew_cycles;
                        slew_pend_nx_s = 1'b1;
                    end else begin
                        slew_cnt_nx_s  = slew_cnt_nx_s;
                    end
                end
                ST_SLEW: begin
                    if (slew_cnt_r <= SLEW_ONE) begin
                        slew_cnt_nx_s = '0;
                        state_nx_s    = ST_RUN;
                    end else begin
                        slew_cnt_nx_s = slew_cnt_r - SLEW_ONE;
                        state_nx_s    = ST_SLEW;
                    end
                    if (cfg_acc_s) begin
                        fcw_p_nx_s    = rx_cfg_fcw;
                        paral_p_nx_s  = rx_cfg_paral;
                        int_p_nx_s    = rx_cfg_int;
                        cfg_pend_nx_s = 1'b1;
                    end else begin
                        cfg_pend_nx_s = cfg_pend_r;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and configuration registers.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_r     <= ST_IDLE;
            fcw_a_r     <= '0;
            paral_a_r   <= 2'd0;
            int_a_r     <= '0;
            fcw_p_r     <= '0;
            paral_p_r   <= 2'd0;
            int_p_r     <= '0;
            cfg_pend_r  <= 1'b0;
            slew_cnt_r  <= '0;
            slew_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            fcw_a_r     <= fcw_a_nx_s;
            paral_a_r   <= paral_a_nx_s;
            int_a_r     <= int_a_nx_s;
            fcw_p_r     <= fcw_p_nx_s;
            paral_p_r   <= paral_p_nx_s;
            int_p_r     <= int_p_nx_s;
            cfg_pend_r  <= cfg_pend_nx_s;
            slew_cnt_r  <= slew_cnt_nx_s;
            slew_pend_r <= slew_pend_nx_s;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            tx_gen_rst    <= 1'b1;
            tx_gen_fcw    <= '0;
            tx_gen_paral  <= 2'd0;
            tx_dump       <= 1'b0;
            tx_epoch_cnt  <= '0;
            tx_busy       <= 1'b0;
            tx_cfg_ready  <= 1'b1;
            tx_slew_ready <= 1'b0;
        end else begin
            tx_gen_rst    <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_LOAD);
            tx_gen_fcw    <= ((state_nx_s == ST_LOAD) || (state_nx_s == ST_RUN)) ? fcw_a_nx_s : '0;
            tx_gen_paral  <= paral_a_nx_s;
            tx_dump       <= dump_nx_s;
            tx_epoch_cnt  <= epoch_nx_s;
            tx_busy       <= (state_nx_s != ST_IDLE);
            tx_cfg_ready  <= ~cfg_pend_nx_s;
            tx_slew_ready <= (state_nx_s == ST_RUN) && ~slew_pend_nx_s;
        end
    end

endmodule

// File: tb/tb_prn_gen_ctrl.sv
// Bench for prn_gen_ctrl: directed scenarios plus random traffic, every cycle
// compared against a mode/count reference model of the sequencing rules.
module tb_prn_gen_ctrl;
    localparam int AW = 32;
    localparam int EW = 6;
    localparam int SW = 16;

    logic          rx_clk = 1'b0;
    logic          rx_rst, rx_start, rx_stop, rx_cfg_valid, rx_slew_valid, rx_prn_eop;
    logic [AW-1:0] rx_cfg_fcw;
    logic [1:0]    rx_cfg_paral;
    logic [EW-1:0] rx_cfg_int;
    logic [SW-1:0] rx_slew_cycles;
    logic          tx_cfg_ready, tx_slew_ready, tx_gen_rst, tx_dump, tx_busy;
    logic [AW-1:0] tx_gen_fcw;
    logic [1:0]    tx_gen_paral;
    logic [EW-1:0] tx_epoch_cnt;

    int total = 0;
    int bad = 0;
    int dump_seen = 0;
    int zero_seen = 0;

    // Reference model: mode 0 idle, 1 load, 2 run, 3 slew
    int          m_mode, m_int, m_int_p, m_epoch, m_slew_req, m_slew_left;
    logic [31:0] m_fcw, m_fcw_p;
    logic [1:0]  m_par, m_par_p;
    bit          m_cpend, m_spend, m_dump;

    always #5 rx_clk = ~rx_clk;

    prn_gen_ctrl #(.ACC_WIDTH(AW), .EPW(EW), .SLEW_WIDTH(SW)) dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_start(rx_start), .rx_stop(rx_stop),
        .rx_cfg_valid(rx_cfg_valid), .tx_cfg_ready(tx_cfg_ready), .rx_cfg_fcw(rx_cfg_fcw),
        .rx_cfg_paral(rx_cfg_paral), .rx_cfg_int(rx_cfg_int), .rx_slew_valid(rx_slew_valid),
        .tx_slew_ready(tx_slew_ready), .rx_slew_cycles(rx_slew_cycles), .rx_prn_eop(rx_prn_eop),
        .tx_gen_rst(tx_gen_rst), .tx_gen_fcw(tx_gen_fcw), .tx_gen_paral(tx_gen_paral),
        .tx_dump(tx_dump), .tx_epoch_cnt(tx_epoch_cnt), .tx_busy(tx_busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic take_pending();
        m_fcw_p = rx_cfg_fcw;
        m_par_p = rx_cfg_paral;
        m_int_p = int'(rx_cfg_int);
        m_cpend = 1'b1;
    endtask

    task automatic model_step();
        bit cfg_acc, slew_acc;
        int lim;
        cfg_acc  = rx_cfg_valid && !m_cpend;
        slew_acc = rx_slew_valid && (m_mode == 2) && !m_spend;
        m_dump   = 1'b0;
        if (rx_rst) begin
            m_mode = 0; m_fcw = 0; m_par = 0; m_int = 0; m_fcw_p = 0; m_par_p = 0; m_int_p = 0;
            m_cpend = 0; m_spend = 0; m_slew_req = 0; m_slew_left = 0; m_epoch = 0;
        end else if (rx_stop) begin
            m_mode = 0; m_cpend = 0; m_spend = 0; m_slew_left = 0; m_epoch = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (cfg_acc) begin
                        m_fcw = rx_cfg_fcw; m_par = rx_cfg_paral; m_int = int'(rx_cfg_int);
                    end
                    if (rx_start) m_mode = 1;
                end
                1: begin
                    if (cfg_acc) take_pending();
                    m_mode = 2;
                end
                2: begin
                    if (rx_prn_eop) begin
                        lim = (m_int == 0) ? 1 : m_int;
                        m_epoch++;
                        if (m_epoch >= lim) begin
                            m_epoch = 0;
                            m_dump  = 1'b1;
                        end
                        if (m_cpend) begin
                            m_fcw = m_fcw_p; m_par = m_par_p; m_int = m_int_p; m_cpend = 0;
                        end
                        if (m_spend) begin
                            m_mode = 3; m_slew_left = m_slew_req; m_spend = 0;
                        end
                    end
                    if (cfg_acc) take_pending();
                    if (slew_acc && rx_slew_cycles != 0) begin
                        m_spend = 1; m_slew_req = int'(rx_slew_cycles);
                    end
                end
                default: begin
                    if (cfg_acc) take_pending();
                    m_slew_left--;
                    if (m_slew_left == 0) m_mode = 2;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check_val("gen_rst",    64'(tx_gen_rst), 64'(m_mode <= 1));
        check_val("gen_fcw",    64'(tx_gen_fcw), 64'((m_mode == 1 || m_mode == 2) ? m_fcw : 32'd0));
        check_val("gen_paral",  64'(tx_gen_paral), 64'(m_par));
        check_val("dump",       64'(tx_dump), 64'(m_dump));
        check_val("epoch_cnt",  64'(tx_epoch_cnt), 64'(m_epoch));
        check_val("busy",       64'(tx_busy), 64'(m_mode != 0));
        check_val("cfg_ready",  64'(tx_cfg_ready), 64'(!m_cpend));
        check_val("slew_ready", 64'(tx_slew_ready), 64'(m_mode == 2 && !m_spend));
    endtask

    task automatic clr();
        rx_rst = 1'b0; rx_start = 1'b0; rx_stop = 1'b0; rx_cfg_valid = 1'b0;
        rx_slew_valid = 1'b0; rx_prn_eop = 1'b0;
    endtask

    task automatic cyc();
        @(posedge rx_clk);
        model_step();
        @(negedge rx_clk);
        compare_all();
        dump_seen += int'(tx_dump);
        if (tx_gen_fcw == 32'd0) zero_seen++;
        clr();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic cfg(input logic [31:0] f, input logic [1:0] p, input logic [5:0] n);
        rx_cfg_valid = 1'b1; rx_cfg_fcw = f; rx_cfg_paral = p; rx_cfg_int = n;
    endtask

    initial begin
        clr();
        rx_cfg_fcw = '0; rx_cfg_paral = 2'd0; rx_cfg_int = '0; rx_slew_cycles = '0;
        rx_rst = 1'b1; cyc();
        rx_rst = 1'b1; cyc();
        idle(2);

        // Configure in IDLE, then start
        cfg(32'h0A3D70A4, 2'd2, 6'd4); cyc();
        rx_start = 1'b1; cyc();
        check_val("load_rst", 64'(tx_gen_rst), 64'd1);
        check_val("load_fcw", 64'(tx_gen_fcw), 64'h0A3D70A4);
        cyc();
        check_val("run_rst", 64'(tx_gen_rst), 64'd0);
        check_val("run_busy", 64'(tx_busy), 64'd1);

        // Twelve epochs, int=4
        dump_seen = 0;
        for (int e = 0; e < 12; e++) begin
            rx_prn_eop = 1'b1; cyc();
            idle(19);
        end
        check_val("dump_count12", 64'(dump_seen), 64'd3);

        // Mid-epoch cfg update applied at next eop
        idle(5);
        cfg(32'h0B000000, 2'd2, 6'd4); cyc();
        idle(8);
        rx_prn_eop = 1'b1; cyc();
        check_val("fcw_swap", 64'(tx_gen_fcw), 64'h0B000000);
        idle(3);

        // Slew of 37 clocks with eops arriving during the freeze
        rx_slew_valid = 1'b1; rx_slew_cycles = 16'd37; cyc();
        idle(4);
        zero_seen = 0;
        for (int i = 0; i < 60; i++) begin
            rx_prn_eop = (i % 15 == 0);
            cyc();
        end
        check_val("slew37_len", 64'(zero_seen), 64'd37);

        // Stop and start together during a slew
        rx_slew_valid = 1'b1; rx_slew_cycles = 16'd10; cyc();
        rx_prn_eop = 1'b1; cyc();
        idle(3);
        rx_stop = 1'b1; rx_start = 1'b1; cyc();
        check_val("stop_rst", 64'(tx_gen_rst), 64'd1);
        check_val("stop_fcw", 64'(tx_gen_fcw), 64'd0);
        idle(3);
        rx_start = 1'b1; cyc();
        check_val("reload_fcw", 64'(tx_gen_fcw), 64'h0B000000);
        idle(3);

        // int=0: dump on every eop; zero-length slew dropped
        rx_stop = 1'b1; cyc();
        cfg(32'h01234567, 2'd1, 6'd0); cyc();
        rx_start = 1'b1; cyc();
        idle(3);
        dump_seen = 0;
        for (int e = 0; e < 4; e++) begin
            rx_prn_eop = 1'b1; cyc();
            idle(4);
        end
        check_val("dump_int0", 64'(dump_seen), 64'd4);
        rx_slew_valid = 1'b1; rx_slew_cycles = 16'd0; cyc();
        rx_prn_eop = 1'b1; cyc();
        check_val("slew0_fcw", 64'(tx_gen_fcw), 64'h01234567);
        idle(3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rx_prn_eop     = ($urandom_range(0, 11) == 0);
            rx_cfg_valid   = ($urandom_range(0, 9) == 0);
            rx_cfg_fcw     = $urandom;
            rx_cfg_paral   = 2'($urandom_range(0, 3));
            rx_cfg_int     = 6'($urandom_range(0, 5));
            rx_slew_valid  = ($urandom_range(0, 7) == 0);
            rx_slew_cycles = 16'($urandom_range(0, 6));
            rx_start       = ($urandom_range(0, 19) == 0);
            rx_stop        = !rx_cfg_valid && ($urandom_range(0, 149) == 0);
            rx_rst         = ($urandom_range(0, 799) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
